// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS32 multicycle control path.
//   - opcode field values (instruction bits [31:26]) handled by the sequencer
//   - FSM state encodings, also visible on the o_state debug port
//   - ALU operation, ALU B-source and PC-source select codes
//   - ctrl_t: the bundle of datapath strobes/selects decoded from the state
//   - decode_target(): DECODE-state dispatch from opcode to the next state
package mips_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // FSM state encodings
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_EXEC_R    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EXEC = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd13;

  // ALU operation codes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B-input select codes
  localparam logic [1:0] ALU_SRC_B_RT     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

  // PC source select codes
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Datapath control bundle
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // Next state out of DECODE; anything unsupported lands in TRAP.
  function automatic logic [3:0] decode_target(input logic [5:0] opcode);
    logic [3:0] nxt;
    case (opcode)
      OP_RTYPE:      nxt = S_EXEC_R;
      OP_LW, OP_SW:  nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE: nxt = S_BRANCH;
      OP_J:          nxt = S_JUMP;
      OP_ADDI:       nxt = S_ADDI_EXEC;
      default:       nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// retire_counter: free-running retired-instruction counter.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low clear
//   inc_i    - add one on this clock edge
//   count_o  - current count, wraps modulo 2^COUNT_W
module retire_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               inc_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-style sequencer for the MIPS32 multicycle datapath.
//
// Ports:
//   Clk, Rst        - clock (rising edge) and asynchronous active-low reset
//   i_opcode        - IR[31:26]; only consulted in DECODE, MEM_ADDR, BRANCH
//   i_zero          - ALU zero flag, qualifies the branch PC write
//   i_mem_ready     - memory finished the current read/write this cycle
//   i_stall         - host freeze: state holds, write strobes forced low
//   o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write - strobes
//   o_memto_reg, o_reg_dst, o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_src - selects
//   o_state         - current state encoding (debug)
//   o_illegal       - sticky unsupported-opcode flag
//   o_retired       - retired-instruction count (COUNT_W bits, wraps)
//
// Handshake: a memory access is requested for as long as the FSM sits in an
// access state; it completes on the first cycle with i_mem_ready=1 and
// i_stall=0. A stalled ready cycle is discarded and the access repeats.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         i_opcode,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  input  logic               i_stall,
  output logic               o_pc_write,
  output logic               o_ir_write,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_memto_reg,
  output logic               o_reg_dst,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [1:0]         o_alu_op,
  output logic [1:0]         o_pc_src,
  output logic [3:0]         o_state,
  output logic               o_illegal,
  output logic [COUNT_W-1:0] o_retired
);

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       retire;
  ctrl_t      ctrl_raw;
  ctrl_t      ctrl;

  // Next-state logic. A stall freezes every transition, including retirement.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (!i_stall) begin
      case (state_q)
        S_IDLE:      state_d = S_FETCH;
        S_FETCH:     if (i_mem_ready) state_d = S_DECODE;
        S_DECODE:    state_d = decode_target(i_opcode);
        S_MEM_ADDR:  state_d = (i_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (i_mem_ready) state_d = S_MEM_WB;
        S_MEM_WRITE: begin
          if (i_mem_ready) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
        S_EXEC_R:    state_d = S_R_WB;
        S_ADDI_EXEC: state_d = S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        S_TRAP:      state_d = S_TRAP;
        // Codes 14/15 are unreachable; recover through IDLE.
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // Set together with the entry into TRAP so the flag is visible in the
  // first TRAP cycle; only reset clears it.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode of the state register; the only input-dependent terms are
  // the memory-ready gating in FETCH and the zero-flag gating in BRANCH.
  always_comb begin
    ctrl_raw = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_raw.mem_read  = 1'b1;
        ctrl_raw.pc_write  = i_mem_ready;
        ctrl_raw.ir_write  = i_mem_ready;
        ctrl_raw.alu_src_a = 1'b0;
        ctrl_raw.alu_src_b = ALU_SRC_B_FOUR;
        ctrl_raw.alu_op    = ALU_OP_ADD;
        ctrl_raw.pc_src    = PC_SRC_ALU;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode decodes.
        ctrl_raw.alu_src_a = 1'b0;
        ctrl_raw.alu_src_b = ALU_SRC_B_IMM_SH;
        ctrl_raw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALU_SRC_B_IMM;
        ctrl_raw.alu_op    = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        ctrl_raw.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.memto_reg = 1'b1;
        ctrl_raw.reg_dst   = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl_raw.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALU_SRC_B_RT;
        ctrl_raw.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.reg_dst   = 1'b1;
        ctrl_raw.memto_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_raw.alu_src_a = 1'b1;
        ctrl_raw.alu_src_b = ALU_SRC_B_RT;
        ctrl_raw.alu_op    = ALU_OP_SUB;
        ctrl_raw.pc_src    = PC_SRC_ALUOUT;
        // Anything reaching BRANCH that is not beq must be bne.
        ctrl_raw.pc_write  = (i_opcode == OP_BEQ) ? i_zero : !i_zero;
      end
      S_JUMP: begin
        ctrl_raw.pc_write = 1'b1;
        ctrl_raw.pc_src   = PC_SRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl_raw.reg_write = 1'b1;
        ctrl_raw.reg_dst   = 1'b0;
      end
      default: ctrl_raw = '0;  // IDLE, TRAP
    endcase
  end

  // Stall masks the state-changing strobes; mem_read and selects stay as decoded.
  always_comb begin
    ctrl = ctrl_raw;
    if (i_stall) begin
      ctrl.pc_write  = 1'b0;
      ctrl.ir_write  = 1'b0;
      ctrl.reg_write = 1'b0;
      ctrl.mem_write = 1'b0;
    end
  end

  retire_counter #(
    .COUNT_W (COUNT_W)
  ) u_retire_counter (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .inc_i   (retire),
    .count_o (o_retired)
  );

  assign o_pc_write  = ctrl.pc_write;
  assign o_ir_write  = ctrl.ir_write;
  assign o_reg_write = ctrl.reg_write;
  assign o_mem_read  = ctrl.mem_read;
  assign o_mem_write = ctrl.mem_write;
  assign o_memto_reg = ctrl.memto_reg;
  assign o_reg_dst   = ctrl.reg_dst;
  assign o_alu_src_a = ctrl.alu_src_a;
  assign o_alu_src_b = ctrl.alu_src_b;
  assign o_alu_op    = ctrl.alu_op;
  assign o_pc_src    = ctrl.pc_src;
  assign o_state     = state_q;
  assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. A wide-counter instance and a 4-bit
// counter instance share all inputs; the narrow one exercises counter wrap.
module tb_multicycle_control;

  // Control bundle as compared: {pc_w, ir_w, reg_w, mem_rd, mem_wr, memto_reg,
  // reg_dst, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0], illegal}
  localparam logic [14:0] C_NONE      = 15'b00000000_00_00_00_0;
  localparam logic [14:0] C_FETCH_RDY = 15'b11010000_01_00_00_0;
  localparam logic [14:0] C_FETCH_WT  = 15'b00010000_01_00_00_0;
  localparam logic [14:0] C_DECODE    = 15'b00000000_11_00_00_0;
  localparam logic [14:0] C_EXEC_R    = 15'b00000001_00_10_00_0;
  localparam logic [14:0] C_R_WB      = 15'b00100010_00_00_00_0;
  localparam logic [14:0] C_MEM_ADDR  = 15'b00000001_10_00_00_0;
  localparam logic [14:0] C_MEM_READ  = 15'b00010000_00_00_00_0;
  localparam logic [14:0] C_MEM_WB    = 15'b00100100_00_00_00_0;
  localparam logic [14:0] C_MEM_WRITE = 15'b00001000_00_00_00_0;
  localparam logic [14:0] C_BR_TAKEN  = 15'b10000001_00_01_01_0;
  localparam logic [14:0] C_BR_NOT    = 15'b00000001_00_01_01_0;
  localparam logic [14:0] C_JUMP      = 15'b10000000_00_00_10_0;
  localparam logic [14:0] C_ADDI_WB   = 15'b00100000_00_00_00_0;
  localparam logic [14:0] C_TRAP      = 15'b00000000_00_00_00_1;

  typedef struct {
    logic        rst_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        ready;
    logic        stall;
    logic [3:0]  exp_state;
    logic [14:0] exp_ctrl;
    logic [31:0] exp_ret;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        stall;

  logic        pc_write, ir_write, reg_write, mem_read, mem_write;
  logic        memto_reg, reg_dst, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        n_pc_write, n_ir_write, n_reg_write, n_mem_read, n_mem_write;
  logic        n_memto_reg, n_reg_dst, n_alu_src_a, n_illegal;
  logic [1:0]  n_alu_src_b, n_alu_op, n_pc_src;
  logic [3:0]  n_state;
  logic [3:0]  n_retired;

  vec_t vecs[$];
  int   n_applied;
  int   n_miscompares;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control dut (
    .Clk(clk), .Rst(rst_n), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .i_stall(stall),
    .o_pc_write(pc_write), .o_ir_write(ir_write), .o_reg_write(reg_write),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_memto_reg(memto_reg),
    .o_reg_dst(reg_dst), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_op(alu_op), .o_pc_src(pc_src), .o_state(state),
    .o_illegal(illegal), .o_retired(retired)
  );

  multicycle_control #(.COUNT_W(4)) dut_w4 (
    .Clk(clk), .Rst(rst_n), .i_opcode(opcode), .i_zero(zero),
    .i_mem_ready(mem_ready), .i_stall(stall),
    .o_pc_write(n_pc_write), .o_ir_write(n_ir_write), .o_reg_write(n_reg_write),
    .o_mem_read(n_mem_read), .o_mem_write(n_mem_write), .o_memto_reg(n_memto_reg),
    .o_reg_dst(n_reg_dst), .o_alu_src_a(n_alu_src_a), .o_alu_src_b(n_alu_src_b),
    .o_alu_op(n_alu_op), .o_pc_src(n_pc_src), .o_state(n_state),
    .o_illegal(n_illegal), .o_retired(n_retired)
  );

  function automatic logic [14:0] act_ctrl();
    return {pc_write, ir_write, reg_write, mem_read, mem_write, memto_reg,
            reg_dst, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [5:0] op, input logic z,
                       input logic rdy, input logic st);
    rst_n     = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    stall     = st;
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic st, input logic [3:0] s,
                     input logic [14:0] c, input logic [31:0] ret);
    vec_t v;
    v.rst_n = r; v.opcode = op; v.zero = z; v.ready = rdy; v.stall = st;
    v.exp_state = s; v.exp_ctrl = c; v.exp_ret = ret;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare(input string name, input logic [3:0] es,
                         input logic [14:0] ec, input logic [31:0] er);
    n_applied++;
    if (state !== es || act_ctrl() !== ec || retired !== er ||
        n_retired !== er[3:0] || n_state !== es) begin
      n_miscompares++;
      $display("FAIL %s: state=%0d want %0d ctrl=%b want %b ret=%0d want %0d ret4=%0d want %0d",
               name, state, es, act_ctrl(), ec, retired, er, n_retired, er[3:0]);
    end
  endtask

  // Check mid-cycle, then advance to just after the next rising edge.
  task automatic cycle_check(input string name, input logic [3:0] es,
                             input logic [14:0] ec, input logic [31:0] er);
    @(negedge clk);
    compare(name, es, ec, er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_applied     = 0;
    n_miscompares = 0;
    drive(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);

    // ---- vector table: one entry per clock cycle ----
    //   rst  opcode zero rdy stall  state  ctrl         retired
    add(1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 4'd0,  C_NONE,      0);  // in reset
    add(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 4'd0,  C_NONE,      0);  // IDLE
    // R-type
    add(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 0);
    add(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    0);
    add(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 4'd7,  C_EXEC_R,    0);
    add(1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 4'd8,  C_R_WB,      0);
    // lw with three wait cycles in MEM_READ
    add(1'b1, 6'h23, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 1);
    add(1'b1, 6'h23, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    1);
    add(1'b1, 6'h23, 1'b0, 1'b1, 1'b0, 4'd3,  C_MEM_ADDR,  1);
    add(1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 4'd4,  C_MEM_READ,  1);
    add(1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 4'd4,  C_MEM_READ,  1);
    add(1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 4'd4,  C_MEM_READ,  1);
    add(1'b1, 6'h23, 1'b0, 1'b1, 1'b0, 4'd4,  C_MEM_READ,  1);
    add(1'b1, 6'h23, 1'b0, 1'b1, 1'b0, 4'd5,  C_MEM_WB,    1);
    // beq, zero=1: taken
    add(1'b1, 6'h04, 1'b1, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 2);
    add(1'b1, 6'h04, 1'b1, 1'b1, 1'b0, 4'd2,  C_DECODE,    2);
    add(1'b1, 6'h04, 1'b1, 1'b1, 1'b0, 4'd9,  C_BR_TAKEN,  2);
    // bne, zero=1: not taken
    add(1'b1, 6'h05, 1'b1, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 3);
    add(1'b1, 6'h05, 1'b1, 1'b1, 1'b0, 4'd2,  C_DECODE,    3);
    add(1'b1, 6'h05, 1'b1, 1'b1, 1'b0, 4'd9,  C_BR_NOT,    3);
    // sw: one wait cycle, then a stalled ready cycle, then completion
    add(1'b1, 6'h2B, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 4);
    add(1'b1, 6'h2B, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    4);
    add(1'b1, 6'h2B, 1'b0, 1'b1, 1'b0, 4'd3,  C_MEM_ADDR,  4);
    add(1'b1, 6'h2B, 1'b0, 1'b0, 1'b0, 4'd6,  C_MEM_WRITE, 4);
    add(1'b1, 6'h2B, 1'b0, 1'b1, 1'b1, 4'd6,  C_NONE,      4);
    add(1'b1, 6'h2B, 1'b0, 1'b1, 1'b0, 4'd6,  C_MEM_WRITE, 4);
    // addi
    add(1'b1, 6'h08, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 5);
    add(1'b1, 6'h08, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    5);
    add(1'b1, 6'h08, 1'b0, 1'b1, 1'b0, 4'd11, C_MEM_ADDR,  5);
    add(1'b1, 6'h08, 1'b0, 1'b1, 1'b0, 4'd12, C_ADDI_WB,   5);
    // j with a two-cycle stall in FETCH (ready held high)
    add(1'b1, 6'h02, 1'b0, 1'b1, 1'b1, 4'd1,  C_FETCH_WT,  6);
    add(1'b1, 6'h02, 1'b0, 1'b1, 1'b1, 4'd1,  C_FETCH_WT,  6);
    add(1'b1, 6'h02, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 6);
    add(1'b1, 6'h02, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    6);
    add(1'b1, 6'h02, 1'b0, 1'b1, 1'b0, 4'd10, C_JUMP,      6);
    // unsupported opcode
    add(1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 4'd1,  C_FETCH_RDY, 7);
    add(1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 4'd2,  C_DECODE,    7);
    add(1'b1, 6'h3F, 1'b0, 1'b1, 1'b0, 4'd13, C_TRAP,      7);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].opcode, vecs[i].zero, vecs[i].ready, vecs[i].stall);
      cycle_check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctrl,
                  vecs[i].exp_ret);
    end

    // ---- TRAP is absorbing for 20 cycles regardless of inputs ----
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
      cycle_check($sformatf("trap_hold%0d", i), 4'd13, C_TRAP, 7);
    end
    // Reset clears the trap and the counter.
    drive(1'b0, 6'h02, 1'b0, 1'b1, 1'b0);
    cycle_check("trap_reset", 4'd0, C_NONE, 0);

    // ---- 16 jumps: the 4-bit counter wraps 15 -> 0 ----
    drive(1'b1, 6'h02, 1'b0, 1'b1, 1'b0);
    cycle_check("wrap_idle", 4'd0, C_NONE, 0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;  // FETCH
      @(posedge clk); #1;  // DECODE
      cycle_check($sformatf("wrap_jump%0d", k), 4'd10, C_JUMP, 32'(k));
    end
    cycle_check("wrap_done", 4'd1, C_FETCH_RDY, 16);

    // ---- reset asserted in MEM_WRITE drops mem_write at once ----
    drive(1'b0, 6'h2B, 1'b0, 1'b1, 1'b0);
    cycle_check("sw_reset", 4'd0, C_NONE, 0);
    drive(1'b1, 6'h2B, 1'b0, 1'b1, 1'b0);
    cycle_check("sw_idle", 4'd0, C_NONE, 0);
    cycle_check("sw_fetch", 4'd1, C_FETCH_RDY, 0);
    cycle_check("sw_decode", 4'd2, C_DECODE, 0);
    drive(1'b1, 6'h2B, 1'b0, 1'b0, 1'b0);
    cycle_check("sw_addr", 4'd3, C_MEM_ADDR, 0);
    @(negedge clk);
    compare("sw_write", 4'd6, C_MEM_WRITE, 0);
    #2;
    rst_n = 1'b0;
    #1;
    compare("sw_async_reset", 4'd0, C_NONE, 0);
    @(posedge clk); #1;
    cycle_check("sw_after_reset", 4'd0, C_NONE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the MIPS32 datapath: PC register, instruction/data memory, register file, ALU and write-address mux.
- Replaces the single-cycle opcode decoder with a Moore FSM.
- Each instruction takes 3-5 cycles. Fetch and data-memory accesses wait on a ready handshake.
- Sits between memory/IR and the datapath enables. Also exports a retired-instruction counter and a trap flag for debug.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- i_opcode  in  6  instruction bits [31:26], taken from the IR.
- i_zero  in  1  ALU zero flag.
- i_mem_ready  in  1  memory has completed the current read/write this cycle.
- i_stall  in  1  freeze request from the debug/host side.
- o_pc_write  out  1  PC load enable.
- o_ir_write  out  1  instruction register load enable.
- o_reg_write  out  1  register-file write enable.
- o_mem_read  out  1  memory read request.
- o_mem_write  out  1  memory write request.
- o_memto_reg  out  1  writeback source: 1 = memory data, 0 = ALUOut.
- o_reg_dst  out  1  write address: 1 = rd [15:11], 0 = rt [20:16].
- o_alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs data.
- o_alu_src_b  out  2  ALU B input: 00 = rt data, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- o_alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
- o_pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- o_state  out  4  current state encoding, for debug.
- o_illegal  out  1  sticky unsupported-opcode trap flag.
- o_retired  out  COUNT_W  retired-instruction count.

Behaviour:
- Reset (Rst low, async): state = IDLE, o_retired = 0, o_illegal = 0.
- In IDLE all strobes are 0 and all selects are 0. One cycle after reset release, IDLE moves to FETCH.
- Outputs are a combinational decode of the state register (Moore), except where gated by i_mem_ready or i_zero.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- FETCH:
  - mem_read = 1; src_a = 0, src_b = 01, op = 00, pc_src = 00.
  - pc_write and ir_write are both equal to i_mem_ready.
  - Stays in FETCH until i_mem_ready, then goes to DECODE.
- DECODE: src_a = 0, src_b = 11, op = 00 (precomputes the branch target). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR
  - 0x04 (beq) or 0x05 (bne) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x08 (addi) -> ADDI_EXEC
  - any other opcode -> TRAP
- MEM_ADDR: src_a = 1, src_b = 10, op = 00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1. Holds until i_mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write = 1, memto_reg = 1, reg_dst = 0. Retires.
- MEM_WRITE: mem_write = 1, held until i_mem_ready. Retires on the ready cycle.
- EXEC_R: src_a = 1, src_b = 00, op = 10. Next is R_WB.
- R_WB: reg_write = 1, reg_dst = 1, memto_reg = 0. Retires.
- BRANCH: src_a = 1, src_b = 00, op = 01, pc_src = 01. Retires.
  - beq: pc_write = i_zero.
  - bne: pc_write = !i_zero.
- JUMP: pc_write = 1, pc_src = 10. Retires.
- ADDI_EXEC: src_a = 1, src_b = 10, op = 00. Next is ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0. Retires.
- Retirement: the state returns to FETCH and o_retired increments by 1. The counter wraps modulo 2^COUNT_W.
- Latency with zero-wait memory: R = 4, lw = 5, sw = 4, beq/bne = 3, j = 3, addi = 4 cycles.
- TRAP: o_illegal = 1, all strobes 0. The state is absorbing; only reset exits it.
- Stall (i_stall = 1, any state):
  - State holds; the counter does not increment.
  - pc_write, ir_write, reg_write and mem_write are forced to 0.
  - mem_read and all selects keep their state values.
  - Stall takes priority over i_mem_ready in the same cycle: the access repeats after the stall.
- Reset asserted mid-instruction: the state is abandoned immediately and no strobe is emitted afterwards.
- The opcode is sampled only in DECODE and in the MEM_ADDR/BRANCH decisions. The IR must stay stable because ir_write is 0 outside FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI
  - the state encodings
  - the ALU_OP and ALU_SRC_B / PC_SRC codes
- One sub-module, retire_counter: COUNT_W-bit counter with increment enable and async active-low clear.
- The FSM stays in multicycle_control.

Test Plan:
- Reset release with i_mem_ready = 1, opcode 0x00 -> states IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH. reg_write = 1 and reg_dst = 1 only in R_WB. o_retired = 1 after 5 cycles.
- lw (0x23) with i_mem_ready low for 3 cycles in MEM_READ -> mem_read = 1 held for 4 cycles, MEM_WB asserts reg_write with memto_reg = 1, total 8 cycles, o_retired increments once.
- beq (0x04) with i_zero = 1, then bne (0x05) with i_zero = 1 -> BRANCH asserts pc_write = 1 with pc_src = 01 for beq; pc_write = 0 for bne. Both retire in 3 cycles.
- Opcode 0x3F -> DECODE then TRAP. o_illegal = 1 and all strobes 0 for 20 cycles. Rst low clears to IDLE with o_illegal = 0.
- i_stall = 1 for 2 cycles during FETCH with i_mem_ready = 1 -> pc_write = 0 and ir_write = 0 during the stall, state stays FETCH, fetch completes on the first unstalled cycle.
- Preload the counter near 2^COUNT_W-1 (COUNT_W = 4, 16 j instructions) -> o_retired wraps from 15 to 0. Rst asserted during MEM_WRITE -> mem_write drops in the same cycle.
